adder_seq_ctrl: RTL and testbench

- Word-serial controller that performs a wide addition (BIT_WIDTH*NUM_WORDS bits) using one shared BIT_WIDTH-bit ripple-carry adder over NUM_WORDS cycles.
- Latches operands on a start handshake and feeds one word per cycle to the adder, least-significant word first.
- Registers the inter-word carry and assembles the wide sum.
- Reports done/overflow. It sits between a requesting datapath and the existing parameterized adder, trading latency for area.

---
 rtl/adder_seq_ctrl_pkg.sv | 24 ++
 rtl/adder_nbit.sv | 32 +++
 rtl/adder_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_adder_seq_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : adder_seq_ctrl_pkg
//  Description : Shared types and helpers for the word-serial wide adder
//                controller (state encoding, index-width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_seq_ctrl_pkg;

    // Controller states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the word index counter: clog2(num_words), never below 1 bit
    function automatic int idx_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage : adder_seq_ctrl_pkg
`default_nettype wire

// File: rtl/adder_nbit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : adder_nbit
//  Description : Parameterized BIT_WIDTH-bit ripple-carry adder slice.
//                overflow is the carry out of the most-significant bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_nbit #(
    parameter int BIT_WIDTH = 4
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    logic [BIT_WIDTH:0] w_carry;

    assign w_carry[0] = carry_in;

    // One full adder per bit, carry rippling upward
    for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign overflow = w_carry[BIT_WIDTH];

endmodule : adder_nbit
`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : adder_seq_ctrl
//  Description : Word-serial controller computing a BIT_WIDTH*NUM_WORDS-bit
//                sum with one shared BIT_WIDTH-bit adder slice, LS word first.
//                Operands latched on start; done pulses when result is valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int NUM_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           start,
    input  logic [BIT_WIDTH*NUM_WORDS-1:0] a_wide,
    input  logic [BIT_WIDTH*NUM_WORDS-1:0] b_wide,
    input  logic                           carry_in,
    output logic                           busy,
    output logic                           done,
    output logic [BIT_WIDTH*NUM_WORDS-1:0] result,
    output logic                           overflow
);

    localparam int                c_W        = BIT_WIDTH * NUM_WORDS;
    localparam int                c_IDX_W    = idx_width(NUM_WORDS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_WORDS - 1);

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_carry;
    logic [c_W-1:0]       r_a;
    logic [c_W-1:0]       r_b;
    logic [c_W-1:0]       r_result;
    logic                 r_overflow;
    logic                 r_busy;
    logic                 r_done;

    logic [BIT_WIDTH-1:0] w_a_word;
    logic [BIT_WIDTH-1:0] w_b_word;
    logic [BIT_WIDTH-1:0] w_sum;
    logic                 w_carry_out;

    // Select the current operand words from the latched operands by index
    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (r_idx == c_IDX_W'(w)) begin
                w_a_word = r_a[w*BIT_WIDTH +: BIT_WIDTH];
                w_b_word = r_b[w*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    adder_nbit #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_adder (
        .a         (w_a_word),
        .b         (w_b_word),
        .carry_in  (r_carry),
        .sum       (w_sum),
        .overflow  (w_carry_out)
    );

    // Controller FSM with index counter, carry, operand and result registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a        <= a_wide;
                        r_b        <= b_wide;
                        r_carry    <= carry_in;
                        r_result   <= '0;
                        r_overflow <= 1'b0;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    for (int w = 0; w < NUM_WORDS; w++) begin
                        if (r_idx == c_IDX_W'(w)) begin
                            r_result[w*BIT_WIDTH +: BIT_WIDTH] <= w_sum;
                        end
                    end
                    r_carry <= w_carry_out;
                    if (r_idx == c_LAST_IDX) begin
                        r_overflow <= w_carry_out;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign overflow = r_overflow;

endmodule : adder_seq_ctrl
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_adder_seq_ctrl
//  Description : Self-checking bench for adder_seq_ctrl (BIT_WIDTH=4,
//                NUM_WORDS=4): directed table, corner sequences, random ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_seq_ctrl;

    localparam int c_BW = 4;
    localparam int c_NW = 4;
    localparam int c_W  = c_BW * c_NW;
    localparam int c_LAT = c_NW + 1;

    logic           clk = 1'b0;
    logic           n_rst;
    logic           start;
    logic [c_W-1:0] a_wide;
    logic [c_W-1:0] b_wide;
    logic           carry_in;
    logic           busy;
    logic           done;
    logic [c_W-1:0] result;
    logic           overflow;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        logic [c_W-1:0] a;
        logic [c_W-1:0] b;
        logic           cin;
        logic [c_W-1:0] res;
        logic           ovf;
    } vec_t;

    vec_t tbl[8];

    adder_seq_ctrl #(
        .BIT_WIDTH (c_BW),
        .NUM_WORDS (c_NW)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .a_wide   (a_wide),
        .b_wide   (b_wide),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Launch one operation and follow it to completion. If 'now' is set the
    // caller is already at the negedge of an IDLE cycle and start goes up
    // immediately; otherwise one more cycle is waited first.
    task automatic run_op(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                          input logic cin, input logic now, input string tag,
                          output logic [c_W-1:0] res, output logic ovf,
                          output int done_cyc);
        int lat;
        int busy_cnt;
        if (!now) @(negedge clk);
        a_wide   = a;
        b_wide   = b;
        carry_in = cin;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        a_wide   = ~a;
        b_wide   = ~b;
        lat      = 1;
        busy_cnt = 0;
        check({tag, " cleared result"}, 32'(result), 32'h0);
        check({tag, " cleared ovf"}, 32'(overflow), 32'h0);
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (busy) busy_cnt++;
        check({tag, " latency"}, 32'(lat), 32'(c_LAT));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(c_LAT));
        res      = result;
        ovf      = overflow;
        done_cyc = cyc;
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done), 32'h0);
        check({tag, " busy dropped"}, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [c_W-1:0] r;
        logic           o;
        logic [c_W:0]   ref_sum;
        logic [c_W-1:0] ra;
        logic [c_W-1:0] rb;
        logic           rc;
        int             dc1;
        int             dc2;
        int             n_done;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tbl[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
        tbl[7] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};

        n_rst    = 1'b0;
        start    = 1'b0;
        a_wide   = '0;
        b_wide   = '0;
        carry_in = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset result", 32'(result), 32'h0);
        check("reset ovf", 32'(overflow), 32'h0);
        n_rst = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, $sformatf("tbl%0d", i), r, o, dc1);
            check($sformatf("tbl%0d result", i), 32'(r), 32'(tbl[i].res));
            check($sformatf("tbl%0d ovf", i), 32'(o), 32'(tbl[i].ovf));
        end

        // Hold after done
        repeat (3) @(negedge clk);
        check("hold result", 32'(result), 32'h0100);
        check("hold ovf", 32'(overflow), 32'h0);

        // Ignored start during ADD plus operand change after acceptance
        @(negedge clk);
        a_wide = 16'h00FF; b_wide = 16'h0001; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        a_wide = 16'h7777; b_wide = 16'h3333;
        @(negedge clk);
        a_wide = 16'h1111; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            if (done) n_done++;
            if (done) check("ignored-start result", 32'(result), 32'h0100);
            @(negedge clk);
        end
        check("ignored-start done count", 32'(n_done), 32'h1);
        check("ignored-start idle", 32'(busy), 32'h0);

        // Back-to-back: second start in the IDLE cycle right after DONE
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, "b2b first", r, o, dc1);
        check("b2b first result", 32'(r), 32'h5555);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b1, "b2b second", r, o, dc2);
        check("b2b second result", 32'(r), 32'h0000);
        check("b2b second ovf", 32'(o), 32'h1);
        check("b2b done spacing", 32'(dc2 - dc1), 32'(c_NW + 2));

        // Asynchronous reset mid-ADD
        @(negedge clk);
        a_wide = 16'h1234; b_wide = 16'h4321; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-abort partial", 32'(result), 32'h0055);
        #2 n_rst = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'h0);
        check("abort done", 32'(done), 32'h0);
        check("abort result", 32'(result), 32'h0);
        check("abort ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        run_op(16'h0FFF, 16'h0000, 1'b1, 1'b0, "post-reset", r, o, dc1);
        check("post-reset result", 32'(r), 32'h1000);
        check("post-reset ovf", 32'(o), 32'h0);

        // Random operations against a plain-arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = c_W'($urandom);
            rb = c_W'($urandom);
            rc = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, ra} + {1'b0, rb} + {{c_W{1'b0}}, rc};
            run_op(ra, rb, rc, 1'b0, $sformatf("rnd%0d", i), r, o, dc1);
            check($sformatf("rnd%0d result a=%h b=%h c=%0d", i, ra, rb, rc), 32'(r), 32'(ref_sum[c_W-1:0]));
            check($sformatf("rnd%0d ovf", i), 32'(o), 32'(ref_sum[c_W]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_adder_seq_ctrl
`default_nettype wire
